// File: rtl/ripple_cla8_pkg.sv
// Shared definitions for the two-slice rippled carry-lookahead adder.
//   WIDTH   : operand/result width (8)
//   NIB     : width of one carry-lookahead slice (4); WIDTH = 2*NIB
//   state_e : control FSM states
package ripple_cla8_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NIB   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/ripple_cla8_cla4.sv
// cla4: 4-bit combinational carry-lookahead adder slice.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   sum  : a + b + cin, low 4 bits
//   cout : carry out of bit 3
// Purely combinational; no clock, reset or state.
import ripple_cla8_pkg::*;

module cla4 (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB:0]   c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    // Each carry expanded from c[i+1] = g[i] | p[i]&c[i] so no carry
    // depends on another carry, only on g, p and cin.
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[NIB-1:0];
    cout = c[NIB];
  end

endmodule

// File: rtl/ripple_cla8.sv
// ripple_cla8: 8-bit adder built from one shared 4-bit CLA slice, used for
// the low nibble in LOW and the high nibble in HIGH, with the low-slice
// carry registered between the two steps.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   en     : level request; must stay high for the whole operation
//   A, B   : unsigned operands (captured in IDLE)
//   c_in   : carry-in (captured in IDLE)
//   Output : registered sum (A+B+c_in) mod 2^WIDTH
//   c_out  : registered carry-out
//   ready  : high while Output/c_out hold the current request's result
import ripple_cla8_pkg::*;

module ripple_cla8 #(
  parameter int unsigned WIDTH = ripple_cla8_pkg::WIDTH,
  parameter int unsigned NIB   = ripple_cla8_pkg::NIB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ready
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             c4_q, c4_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;

  logic [NIB-1:0]   slice_a, slice_b, slice_s;
  logic             slice_ci, slice_co;

  // Operand nibble and carry-in selection for the shared slice.
  always_comb begin
    if (state_q == HIGH) begin
      slice_a  = a_q[WIDTH-1:NIB];
      slice_b  = b_q[WIDTH-1:NIB];
      slice_ci = c4_q;
    end else begin
      slice_a  = a_q[NIB-1:0];
      slice_b  = b_q[NIB-1:0];
      slice_ci = cin_q;
    end
  end

  cla4 u_cla4 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_ci),
    .sum  (slice_s),
    .cout (slice_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    c4_d    = c4_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          a_d     = A;
          b_d     = B;
          cin_d   = c_in;
          state_d = LOW;
        end
      end
      LOW: begin
        if (en) begin
          sum_d[NIB-1:0] = slice_s;
          c4_d           = slice_co;
          state_d        = HIGH;
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (en) begin
          sum_d[WIDTH-1:NIB] = slice_s;
          cout_d             = slice_co;
          ready_d            = 1'b1;
          state_d            = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (en) begin
          ready_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      c4_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      c4_q    <= c4_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
    end
  end

  assign Output = sum_q;
  assign c_out  = cout_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_ripple_cla8.sv
module tb_ripple_cla8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] A;
  logic [7:0] B;
  logic       c_in;
  logic [7:0] Output;
  logic       c_out;
  logic       ready;

  int unsigned total;
  int unsigned bad;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [13];

  ripple_cla8 #(.WIDTH(8), .NIB(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .A      (A),
    .B      (B),
    .c_in   (c_in),
    .Output (Output),
    .c_out  (c_out),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full request: drive at a negedge, check ready latency, result, hold in
  // DONE (with operand churn), then release en and check ready clears.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec,
                        input logic chg, input logic [7:0] new_a);
    A = a; B = b; c_in = cin; en = 1'b1;
    @(negedge clk);
    if (chg) A = new_a;
    chk({tag, "_rdy1"}, {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_rdy2"}, {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_rdy3"}, {31'd0, ready}, 32'd1);
    chk({tag, "_sum"},  {24'd0, Output}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, c_out}, {31'd0, ec});
    A = ~a; B = ~b; c_in = ~cin;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({tag, "_hold_rdy"}, {31'd0, ready}, 32'd1);
      chk({tag, "_hold_sum"}, {24'd0, Output}, {24'd0, es});
    end
    en = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_rdy"}, {31'd0, ready}, 32'd0);
    chk({tag, "_keep_sum"}, {24'd0, Output}, {24'd0, es});
    chk({tag, "_keep_cout"}, {31'd0, c_out}, {31'd0, ec});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{8'h0C, 8'h01, 1'b0, 8'h0D, 1'b0};
    vecs[1]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[2]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6]  = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[8]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
    vecs[9]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[11] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1};
    vecs[12] = '{8'h08, 8'h08, 1'b0, 8'h10, 1'b0};

    rst_n = 1'b0; en = 1'b0; A = 8'h5A; B = 8'hA5; c_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy",  {31'd0, ready}, 32'd0);
    chk("rst_sum",  {24'd0, Output}, 32'd0);
    chk("rst_cout", {31'd0, c_out}, 32'd0);

    // en high from reset release: 12 + 1.
    rst_n = 1'b1;
    run_op("first", 8'd12, 8'd1, 1'b0, 8'd13, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].sum, vecs[i].cout, 1'b0, 8'h00);

    // Operand change after the capture edge is ignored.
    run_op("late_a", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b1, 8'hFF);

    // Abort in HIGH: ready must never rise.
    A = 8'h11; B = 8'h22; c_in = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_hi_rdy", {31'd0, ready}, 32'd0);
    end
    run_op("after_abort_hi", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Abort in LOW.
    A = 8'h01; B = 8'h01; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_lo_rdy", {31'd0, ready}, 32'd0);
    end
    run_op("after_abort_lo", 8'h3C, 8'h0C, 1'b1, 8'h49, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-operation, with a prior non-zero result held.
    run_op("pre_rst", 8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b1, 1'b0, 8'h00);
    A = 8'hA5; B = 8'h5A; c_in = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy",  {31'd0, ready}, 32'd0);
    chk("arst_sum",  {24'd0, Output}, 32'd0);
    chk("arst_cout", {31'd0, c_out}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    chk("arst_hold_sum", {24'd0, Output}, 32'd0);
    rst_n = 1'b1;
    run_op("after_rst", 8'h99, 8'h77, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ripple_cla8.md
RIPPLE_CLA8 -- requirements
Module: ripple_cla8

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; only 8 need be supported.
REQ-002 Parameter: NIB, default 4, width of one carry-lookahead slice; WIDTH = 2*NIB.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  operation request; level-sensitive, must stay high for the whole operation.
REQ-006 A  input  8  operand A, unsigned.
REQ-007 B  input  8  operand B, unsigned.
REQ-008 c_in  input  1  carry-in.
REQ-009 Output  output  8  registered sum (A+B+c_in) mod 256.
REQ-010 c_out  output  1  registered carry-out, bit 8 of A+B+c_in.
REQ-011 ready  output  1  registered; high when Output/c_out hold the result of the current request.

Function
REQ-012 Adder SHALL be two 4-bit carry-lookahead slices rippled: low slice gets c_in, high slice gets low-slice carry-out c4.
REQ-013 Each slice SHALL compute g=a&b and p=a^b, carries c[i+1]=g[i]|p[i]&c[i] in flattened lookahead form, sum=p^c.
REQ-014 Control SHALL be an FSM with states IDLE, LOW, HIGH, DONE.
REQ-015 IDLE: if en=1 at a rising edge, latch A, B, c_in into internal operand registers, go to LOW; else stay in IDLE.
REQ-016 LOW: register low-slice sum into Output[3:0] and c4 into an internal register, go to HIGH.
REQ-017 HIGH: register high-slice sum into Output[7:4] and its carry into c_out, set ready=1, go to DONE.
REQ-018 Latency: ready SHALL rise right after the third rising edge at which en=1 is sampled, starting from IDLE.
REQ-019 DONE: while en=1, hold state, Output, c_out, and ready=1; no new operation starts.
REQ-020 DONE with en=0: go to IDLE, clear ready; Output and c_out keep their values.
REQ-021 A new operation SHALL need en to go low (return to IDLE) and then high again.
REQ-022 en=0 in LOW or HIGH: abort to IDLE, ready stays 0; partially updated Output bits are allowed but not valid.
REQ-023 A, B, c_in changes after the IDLE capture edge SHALL NOT affect the result.
REQ-024 Overflow wraps modulo 256, with c_out=1; no other status is produced.
REQ-025 Output and c_out SHALL change only on the LOW/HIGH transitions or at reset.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, set state IDLE, and clear ready, Output, c_out, c4 and the operand registers.
REQ-027 Reset mid-operation SHALL abort it; after rst_n rises, a new operation needs en sampled high in IDLE.
REQ-028 rst_n deassertion SHALL be synchronized externally; the block needs no internal synchronizer.

Structure
REQ-029 A shared package SHALL hold WIDTH, NIB and the FSM state enum (IDLE, LOW, HIGH, DONE; 2-bit encoding).
REQ-030 One sub-module cla4 (4-bit combinational carry-lookahead adder: a, b, cin -> sum, cout) SHALL be used; the single registered datapath shares it between LOW and HIGH, muxing operand nibbles and carry-in by state.
REQ-031 cla4 SHALL have no clock, reset or state; all registers live in ripple_cla8.

Verification
REQ-032 A=12, B=1, c_in=0, en high from reset-release -> after 3 edges ready=1, Output=13, c_out=0; held while en=1; ready=0 one edge after en falls, Output stays 13.
REQ-033 A=0x0F, B=0x01, c_in=0 -> Output=0x10, c_out=0 (checks nibble carry c4).
REQ-034 A=0xFF, B=0x01, c_in=0 -> Output=0x00, c_out=1; A=0xFF, B=0xFF, c_in=1 -> Output=0xFF, c_out=1.
REQ-035 Start A=0x33, B=0x44, change A to 0xFF after the capture edge -> Output=0x77, c_out=0.
REQ-036 Drop en in HIGH -> ready never rises, FSM returns to IDLE; next full request (A=0x80, B=0x80) -> Output=0x00, c_out=1.
REQ-037 Assert rst_n=0 mid-operation, between clock edges -> ready, Output, c_out are 0 at once; a new request completes normally.
